// File: rtl/axis_frame_checker.sv
//------------------------------------------------------------------------------
// axis_frame_checker: AXI4-Stream video sink with patterned backpressure,
// framing-error detection and per-frame rotate-XOR checksum.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_frame_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 300
) (
    input  logic                  m_axis_mm2s_aclk,
    input  logic                  m_axis_mm2s_aresetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [7:0]            i_ready_pattern,
    input  logic                  i_err_clear,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_count,
    output logic [31:0]           o_checksum,
    output logic [15:0]           o_x,
    output logic [15:0]           o_y,
    output logic                  o_err_no_sof,
    output logic                  o_err_early_sof,
    output logic                  o_err_early_eol,
    output logic                  o_err_late_eol
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

    state_t      state_q, state_d;
    logic [2:0]  phase_q;
    logic        tready_q;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [31:0] cs_q, cs_d, checksum_q, checksum_d;
    logic [15:0] count_q, count_d;
    logic        done_q, done_d;
    logic        no_sof_q, no_sof_d, early_sof_q, early_sof_d;
    logic        early_eol_q, early_eol_d, late_eol_q, late_eol_d;

    logic        beat;
    logic        take;
    logic        line_end;
    logic [15:0] px, py;
    logic [31:0] data32;

    assign beat   = s_axis_tvalid & tready_q;
    assign data32 = 32'(s_axis_tdata);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cs_d        = cs_q;
        checksum_d  = checksum_q;
        count_d     = count_q;
        done_d      = 1'b0;
        no_sof_d    = no_sof_q    & ~i_err_clear;
        early_sof_d = early_sof_q & ~i_err_clear;
        early_eol_d = early_eol_q & ~i_err_clear;
        late_eol_d  = late_eol_q  & ~i_err_clear;
        take        = 1'b0;
        line_end    = 1'b0;
        px          = x_q;
        py          = y_q;

        if (beat) begin
            // An SOF beat always starts a fresh frame at pixel (0,0).
            if (s_axis_tuser) begin
                if (state_q == ACTIVE) early_sof_d = 1'b1;
                cs_d = data32;
                px   = 16'd0;
                py   = 16'd0;
                take = 1'b1;
            end else if (state_q == IDLE) begin
                no_sof_d = 1'b1;
            end else begin
                cs_d = {cs_q[30:0], cs_q[31]} ^ data32;
                take = 1'b1;
            end

            if (take) begin
                line_end = s_axis_tlast | (px == X_LAST);
                if (s_axis_tlast && (px < X_LAST))  early_eol_d = 1'b1;
                if (!s_axis_tlast && (px == X_LAST)) late_eol_d = 1'b1;
                state_d = ACTIVE;
                if (line_end) begin
                    x_d = 16'd0;
                    if (py == Y_LAST) begin
                        checksum_d = cs_d;
                        count_d    = count_q + 16'd1;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                        y_d        = 16'd0;
                    end else begin
                        y_d = py + 16'd1;
                    end
                end else begin
                    x_d = px + 16'd1;
                    y_d = py;
                end
            end
        end
    end

    always_ff @(posedge m_axis_mm2s_aclk or negedge m_axis_mm2s_aresetn) begin
        if (!m_axis_mm2s_aresetn) begin
            state_q     <= IDLE;
            phase_q     <= 3'd0;
            tready_q    <= 1'b0;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            cs_q        <= 32'd0;
            checksum_q  <= 32'd0;
            count_q     <= 16'd0;
            done_q      <= 1'b0;
            no_sof_q    <= 1'b0;
            early_sof_q <= 1'b0;
            early_eol_q <= 1'b0;
            late_eol_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_q + 3'd1;
            tready_q    <= i_ready_pattern[phase_q];
            x_q         <= x_d;
            y_q         <= y_d;
            cs_q        <= cs_d;
            checksum_q  <= checksum_d;
            count_q     <= count_d;
            done_q      <= done_d;
            no_sof_q    <= no_sof_d;
            early_sof_q <= early_sof_d;
            early_eol_q <= early_eol_d;
            late_eol_q  <= late_eol_d;
        end
    end

    assign s_axis_tready   = tready_q;
    assign o_frame_done    = done_q;
    assign o_frame_count   = count_q;
    assign o_checksum      = checksum_q;
    assign o_x             = x_q;
    assign o_y             = y_q;
    assign o_err_no_sof    = no_sof_q;
    assign o_err_early_sof = early_sof_q;
    assign o_err_early_eol = early_eol_q;
    assign o_err_late_eol  = late_eol_q;

endmodule

`default_nettype wire

// File: doc/axis_frame_checker.md
# axis_frame_checker

Downstream AXI4-Stream sink for the video pipeline's `m_axis_mm2s` output channel, used in the camera testbench. It drives `tready` from a programmable 8-phase backpressure pattern and tracks pixel/line/frame position against the configured geometry. It flags framing errors (missing/early SOF, early/late EOL) and produces a per-frame rotate-XOR checksum plus frame count for scoreboard comparison.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `tdata`; must be ≤ 32.
- `IMG_WIDTH`, 400: pixels (beats) per line, ≥ 2.
- `IMG_HEIGHT`, 300: lines per frame, ≥ 1.

Ports:
- `m_axis_mm2s_aclk`, in, 1: the block's only clock.
- `m_axis_mm2s_aresetn`, in, 1: asynchronous, active-low reset.
- `s_axis_tvalid`, in, 1: stream valid.
- `s_axis_tready`, out, 1: stream ready, registered.
- `s_axis_tuser`, in, 1: start of frame (SOF), first pixel.
- `s_axis_tlast`, in, 1: end of line (EOL).
- `s_axis_tdata`, in, `DATA_WIDTH`: pixel data.
- `i_ready_pattern`, in, 8: `tready` pattern; bit n is used in phase n.
- `i_err_clear`, in, 1: synchronous clear of the sticky error flags.
- `o_frame_done`, out, 1: one-cycle pulse when a frame completes.
- `o_frame_count`, out, 16: count of completed frames, wraps.
- `o_checksum`, out, 32: checksum of the last completed frame.
- `o_x`, out, 16: current pixel index within the line.
- `o_y`, out, 16: current line index within the frame.
- `o_err_no_sof`, out, 1: sticky; a beat was dropped while waiting for SOF.
- `o_err_early_sof`, out, 1: sticky; `tuser` arrived mid-frame.
- `o_err_early_eol`, out, 1: sticky; `tlast` with x < `IMG_WIDTH`-1.
- `o_err_late_eol`, out, 1: sticky; no `tlast` at x = `IMG_WIDTH`-1.

## Operation
- A beat is `s_axis_tvalid & s_axis_tready`. Nothing happens on a cycle without a beat, except the ready generator.
- Ready generator: 3-bit `phase` increments every clock and wraps 7→0. Each clock, `s_axis_tready <= i_ready_pattern[phase]`.
  - 8'hFF gives full throughput; 8'h00 stalls permanently.
  - Pattern changes take effect within one clock.
- State machine has two states, IDLE and ACTIVE.
- IDLE:
  - Beat with `tuser`=0: dropped; set `err_no_sof`.
  - Beat with `tuser`=1: start frame. Set cs = tdata (zero-extended to 32 bits), x = 1, y = 0, go to ACTIVE.
- ACTIVE, every beat: cs = {cs[30:0], cs[31]} ^ zero-extended tdata.
- ACTIVE, beat with `tuser`=1: set `err_early_sof`. Restart the frame exactly as in IDLE; this beat is the new frame's first pixel.
- ACTIVE, line end occurs when `tlast`=1 or x = `IMG_WIDTH`-1:
  - `tlast`=1 with x < `IMG_WIDTH`-1: set `err_early_eol`.
  - x = `IMG_WIDTH`-1 with `tlast`=0: set `err_late_eol`; the line is still terminated at the geometry boundary to realign.
  - On line end: x = 0. If y = `IMG_HEIGHT`-1, the frame completes; otherwise y increments.
- ACTIVE, any other beat: x increments.
- Frame completion, on the next clock edge:
  - `o_checksum` ← final cs (including the last beat).
  - `o_frame_count` increments, wrapping at 0xFFFF→0.
  - `o_frame_done` = 1 for one cycle.
  - State returns to IDLE; x = 0, y = 0.
- Frame-size special cases:
  - `IMG_HEIGHT`=1: the first line end completes the frame.
  - A single-beat SOF carrying `tlast` with `IMG_WIDTH`>1 is an early EOL.
- Sticky flags are cleared by `i_err_clear`. If a set condition occurs in the same cycle as `i_err_clear`, set wins.
- `o_x` and `o_y` reflect the internal counters, registered.

## Timing
- Reset values: `s_axis_tready`=0, phase=0, state IDLE, x=y=0, cs=0, `o_checksum`=0, `o_frame_count`=0, `o_frame_done`=0, all error flags 0.
- First `tready` value appears on the first clock after reset deassertion, i.e. `i_ready_pattern[0]`.
- Reset asserted mid-frame: the partial frame is discarded and no `o_frame_done` is produced.
- All outputs are registered. `o_frame_done` and `o_checksum` update in the cycle after the final beat.
- A new SOF beat may be accepted the cycle after the final beat, so back-to-back frames are supported with no dead cycle.
- At pattern 8'hFF the block sustains 1 beat/clock.

## Test plan
- `IMG_WIDTH`=4, `IMG_HEIGHT`=2, pattern 8'hFF. Send data 1..8 with SOF on 1 and `tlast` on 4 and 8. Expect one `o_frame_done` pulse the cycle after beat 8, `o_checksum`=32'h00000016, `o_frame_count`=1, no errors.
- Same frame with pattern 8'b01010101. Expect `tready` toggling every clock, 16 cycles to drain, identical checksum, no errors.
- Send 3 beats without `tuser`, then a valid frame. Expect `err_no_sof`=1 and checksum 32'h16, and `frame_count` increments by exactly 1.
- Frame with `tlast` on beat 3 of line 0. Expect `err_early_eol`=1; y advances after beat 3; the frame completes after 7 beats total.
- Frame with no `tlast` at all. Expect `err_late_eol`=1 and the frame completes after 8 beats. Then assert `i_err_clear` and expect the flags return to 0.
- Assert `tuser` on beat 6, then send 8 more clean beats. Expect `err_early_sof`=1, then a single `frame_done` after the new 8 beats. Also assert reset mid-frame and expect all outputs at reset values and no `frame_done`.
